// File: rtl/memory_writeback_cycle.sv
// Memory stage data memory plus MEM/WB pipeline register.
// A 64 x 32 byte-lane data memory takes sb/sh/sw stores on the rising clock edge.
// Loads read it combinationally and are size-extended before capture.
// The MEM/WB register then drives the register-file write port for one cycle.
// The asynchronous active-low reset clears the memory and the pipeline register.
module memory_writeback_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RDM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        RegWriteW,
    output logic [4:0]  RDW,
    output logic [31:0] ResultW
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WORDS = 64;

    // Address split: bits [31:8] are ignored, so the address space wraps every 256 bytes.
    logic [5:0]  word_idx;
    logic [1:0]  byte_off;

    // Store path
    logic [3:0]  store_lanes;
    logic [31:0] store_data;
    logic        store_en;

    // Load path
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    // Data memory storage
    logic [31:0] mem [WORDS];

    // MEM/WB pipeline register
    logic        reg_write_w;
    logic        result_src_w;
    logic [4:0]  rd_w;
    logic [31:0] alu_result_w;
    logic [31:0] load_data_w;

    assign word_idx = ALUResultM[7:2];
    assign byte_off = ALUResultM[1:0];

    // Store byte-lane enables.
    // Only sb/sh/sw produce lanes; every other funct3 leaves the memory untouched.
    always_comb begin
        store_lanes = 4'b0000;
        case (funct3M)
            F3_B: begin
                case (byte_off)
                    2'd0:    store_lanes = 4'b0001;
                    2'd1:    store_lanes = 4'b0010;
                    2'd2:    store_lanes = 4'b0100;
                    default: store_lanes = 4'b1000;
                endcase
            end
            F3_H: begin
                // Halfword lanes come from addr[1] only; addr[0] is ignored.
                if (byte_off[1]) begin
                    store_lanes = 4'b1100;
                end else begin
                    store_lanes = 4'b0011;
                end
            end
            F3_W: begin
                store_lanes = 4'b1111;
            end
            default: begin
                store_lanes = 4'b0000;
            end
        endcase
    end

    // Replicate the store data across all lanes.
    // The lane enables then pick which bytes actually land in memory.
    always_comb begin
        store_data = WriteDataM;
        case (funct3M)
            F3_B:    store_data = {4{WriteDataM[7:0]}};
            F3_H:    store_data = {2{WriteDataM[15:0]}};
            default: store_data = WriteDataM;
        endcase
    end

    assign store_en = MemWriteM;

    // Data memory.
    // Reset clears every word asynchronously; stores write only the enabled lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (store_lanes[b]) begin
                    mem[word_idx][b*8 +: 8] <= store_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_word = mem[word_idx];

    // Select the addressed byte and halfword of the word read from memory.
    always_comb begin
        rd_byte = rd_word[7:0];
        case (byte_off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Size and sign handling for loads; any unlisted funct3 reads as zero.
    always_comb begin
        load_data = '0;
        case (funct3M)
            F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_W:    load_data = rd_word;
            F3_BU:   load_data = {24'd0, rd_byte};
            F3_HU:   load_data = {16'd0, rd_half};
            default: load_data = '0;
        endcase
    end

    // MEM/WB register.
    // It captures on every edge, since there is no stall or flush.
    // The write enable is cleared for x0 here, so the register file never sees it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            rd_w         <= '0;
            alu_result_w <= '0;
            load_data_w  <= '0;
        end else begin
            reg_write_w  <= RegWriteM && (RDM != 5'd0);
            result_src_w <= ResultSrcM;
            rd_w         <= RDM;
            alu_result_w <= ALUResultM;
            load_data_w  <= load_data;
        end
    end

    // Writeback result mux after the register.
    always_comb begin
        RegWriteW = reg_write_w;
        RDW       = rd_w;
        ResultW   = result_src_w ? load_data_w : alu_result_w;
    end

endmodule
